// File: rtl/bitstream_serializer.sv
// Turns a stream of small per-cycle counts back into one serial 1-bit stream.
// Counts bank into a saturating residual; one unit drains per cycle as a '1'.
module bitstream_serializer #(
  parameter int unsigned IN_WIDTH  = 2,
  parameter int unsigned ACC_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 clr,
  input  logic                 count_valid,
  input  logic [IN_WIDTH-1:0]  count_in,
  output logic                 bit_out,
  output logic [ACC_WIDTH-1:0] acc_level,
  output logic                 empty,
  output logic                 overflow
);

  localparam int unsigned SUM_WIDTH = ACC_WIDTH + 1;
  localparam logic [SUM_WIDTH-1:0] ACC_MAX = {1'b0, {ACC_WIDTH{1'b1}}};

  logic [SUM_WIDTH-1:0] sum;
  logic [SUM_WIDTH-1:0] rem;
  logic [ACC_WIDTH-1:0] acc_next;
  logic                 bit_next;
  logic                 overflow_next;

  // One extra bit of headroom so acc + count never wraps before the clamp.
  always_comb begin
    acc_next      = acc_level;
    bit_next      = 1'b0;
    overflow_next = overflow;
    sum           = {1'b0, acc_level} + (count_valid ? SUM_WIDTH'(count_in) : '0);
    rem           = '0;
    if (clr) begin
      acc_next = '0;
      bit_next = 1'b0;
    end else begin
      if (sum != '0) begin
        bit_next = 1'b1;
        rem      = sum - SUM_WIDTH'(1);
      end
      if (rem > ACC_MAX) begin
        acc_next      = '1;
        overflow_next = 1'b1;
      end else begin
        acc_next = ACC_WIDTH'(rem);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_level <= '0;
      bit_out   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      acc_level <= acc_next;
      bit_out   <= bit_next;
      overflow  <= overflow_next;
    end
  end

  assign empty = (acc_level == '0);

endmodule
